// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - RV32I execute stage: immediate generator, branch comparator and ALU
// Every output is registered exactly once; there is no stall or handshake.
module exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [24:0]     i_instr,
  input  logic [2:0]      i_imm_sel,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_opa_sel,
  input  logic            i_opb_sel,
  input  logic [3:0]      i_alu_op,
  input  logic            i_br_un,
  output logic [XLEN-1:0] o_alu_data,
  output logic [XLEN-1:0] o_imm,
  output logic            o_br_less,
  output logic            o_br_equal
);

  // Indexed by true instruction bit number so the formats read like the ISA manual.
  logic [31:7] ins;
  assign ins = i_instr;

  logic [XLEN-1:0] imm_d, op_a, op_b, alu_d;
  logic [XLEN-1:0] alu_q, imm_q;
  logic            less_d, equal_d, less_q, equal_q;
  logic [4:0]      shamt;

  always_comb begin
    imm_d = '0;
    case (i_imm_sel)
      3'b000:  imm_d = {{20{ins[31]}}, ins[31:20]};
      3'b001:  imm_d = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010:  imm_d = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011:  imm_d = {ins[31:12], 12'b0};
      3'b100:  imm_d = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end

  // Operand B uses this cycle's immediate, not the registered copy.
  assign op_a  = i_opa_sel ? i_pc  : i_rs1_data;
  assign op_b  = i_opb_sel ? imm_d : i_rs2_data;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_d = '0;
    case (i_alu_op)
      4'd0:    alu_d = op_a + op_b;
      4'd1:    alu_d = op_a - op_b;
      4'd2:    alu_d = op_a << shamt;
      4'd3:    alu_d = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_d = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd5:    alu_d = op_a ^ op_b;
      4'd6:    alu_d = op_a >> shamt;
      4'd7:    alu_d = $signed(op_a) >>> shamt;
      4'd8:    alu_d = op_a | op_b;
      4'd9:    alu_d = op_a & op_b;
      4'd10:   alu_d = op_b;
      default: alu_d = '0;
    endcase
  end

  // Branch flags look at the raw register values, never the muxed operands.
  assign equal_d = (i_rs1_data == i_rs2_data);
  assign less_d  = i_br_un ? (i_rs1_data < i_rs2_data)
                           : ($signed(i_rs1_data) < $signed(i_rs2_data));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      alu_q   <= '0;
      imm_q   <= '0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      less_q  <= less_d;
      equal_q <= equal_d;
    end
  end

  assign o_alu_data = alu_q;
  assign o_imm      = imm_q;
  assign o_br_less  = less_q;
  assign o_br_equal = equal_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - self-checking bench for exec_unit against an arithmetic reference model
module tb_exec_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [24:0] i_instr;
  logic [2:0]  i_imm_sel;
  logic [31:0] i_pc, i_rs1_data, i_rs2_data;
  logic        i_opa_sel, i_opb_sel, i_br_un;
  logic [3:0]  i_alu_op;
  logic [31:0] o_alu_data, o_imm;
  logic        o_br_less, o_br_equal;

  logic [31:0] ins;
  assign i_instr = ins[31:7];

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] prev_alu;
  bit          have_prev = 0;

  always #5 i_clk = ~i_clk;

  exec_unit #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_imm_sel(i_imm_sel),
    .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_opa_sel(i_opa_sel), .i_opb_sel(i_opb_sel), .i_alu_op(i_alu_op), .i_br_un(i_br_un),
    .o_alu_data(o_alu_data), .o_imm(o_imm), .o_br_less(o_br_less), .o_br_equal(o_br_equal)
  );

  function automatic logic [31:0] m_imm(input logic [31:0] w, input logic [2:0] sel);
    logic signed [31:0] s;
    logic [31:0] sgn;
    s   = w;
    sgn = 32'(s >>> 31);
    case (sel)
      3'd0: return 32'(s >>> 20);
      3'd1: return (32'(s >>> 25) << 5) | 32'(w[11:7]);
      3'd2: return (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      3'd3: return w & 32'hFFFF_F000;
      3'd4: return (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int sh;
    longint sa, sb;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  return 32'(64'(a) + 64'(b));
      4'd1:  return 32'(64'(a) - 64'(b));
      4'd2:  return 32'(64'(a) * (64'd1 << sh));
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return 32'(64'(a) / (64'd1 << sh));
      4'd7:  return 32'(sa >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                        input logic [31:0] w, input logic [2:0] isel, input logic oa,
                        input logic ob, input logic [3:0] op, input logic un);
    i_rs1_data = rs1; i_rs2_data = rs2; i_pc = pc; ins = w; i_imm_sel = isel;
    i_opa_sel = oa; i_opb_sel = ob; i_alu_op = op; i_br_un = un;
  endtask

  // Checks the previous result is still held, clocks once, then checks the model.
  task automatic step(input string tag);
    logic [31:0] e_imm, a, b, e_alu;
    logic e_less, e_eq;
    if (have_prev) chk({tag, "_hold"}, o_alu_data, prev_alu);
    @(posedge i_clk);
    #1;
    e_imm  = m_imm(ins, i_imm_sel);
    a      = i_opa_sel ? i_pc : i_rs1_data;
    b      = i_opb_sel ? e_imm : i_rs2_data;
    e_alu  = m_alu(a, b, i_alu_op);
    e_eq   = (i_rs1_data == i_rs2_data);
    e_less = i_br_un ? (64'(i_rs1_data) < 64'(i_rs2_data))
                     : (longint'($signed(i_rs1_data)) < longint'($signed(i_rs2_data)));
    chk({tag, "_alu"}, o_alu_data, e_alu);
    chk({tag, "_imm"}, o_imm, e_imm);
    chk({tag, "_less"}, {31'd0, o_br_less}, {31'd0, e_less});
    chk({tag, "_equal"}, {31'd0, o_br_equal}, {31'd0, e_eq});
    prev_alu  = e_alu;
    have_prev = 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_alu"}, o_alu_data, 32'd0);
    chk({tag, "_imm"}, o_imm, 32'd0);
    chk({tag, "_flags"}, {30'd0, o_br_less, o_br_equal}, 32'd0);
  endtask

  initial begin
    i_reset = 1'b1;
    set_in(32'h1111, 32'h1111, 32'h40, 32'hFFF0_0000, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1 chk_zero("reset_held");

    set_in(32'd5, 32'd7, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    #2 i_reset = 1'b0;
    prev_alu = 32'd0; have_prev = 1;
    step("add_rr");
    chk("add_rr_lit", o_alu_data, 32'd12);

    set_in(32'd5, 32'd7, 32'h0, 32'hFFF0_0000, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0);
    step("addi");
    chk("addi_imm_lit", o_imm, 32'hFFFF_FFFF);
    chk("addi_alu_lit", o_alu_data, 32'd4);

    set_in(32'd0, 32'd0, 32'h0, {7'h7F, 13'd0, 5'h1E, 7'd0}, 3'd1, 1'b0, 1'b0, 4'd0, 1'b0);
    step("imm_s");
    chk("imm_s_lit", o_imm, 32'hFFFF_FFFE);
    ins = {20'h12345, 12'h0}; i_imm_sel = 3'd3;
    step("imm_u");
    chk("imm_u_lit", o_imm, 32'h1234_5000);
    ins = 32'h8000_0000; i_imm_sel = 3'd2;
    step("imm_b");
    chk("imm_b_lit", o_imm, 32'hFFFF_F000);
    i_imm_sel = 3'd4;
    step("imm_j");
    chk("imm_j_lit", o_imm, 32'hFFF0_0000);
    ins = 32'hFFFF_FFFF; i_imm_sel = 3'd7;
    step("imm_none");
    chk("imm_none_lit", o_imm, 32'd0);

    set_in(32'h8000_0000, 32'd31, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 4'd7, 1'b0);
    step("sra31");
    chk("sra31_lit", o_alu_data, 32'hFFFF_FFFF);
    i_alu_op = 4'd6;
    step("srl31");
    chk("srl31_lit", o_alu_data, 32'd1);
    set_in(32'd1, 32'h21, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 4'd2, 1'b0);
    step("sll33");
    chk("sll33_lit", o_alu_data, 32'd2);
    set_in(32'hDEAD_BEEF, 32'h20, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 4'd6, 1'b0);
    step("shift0");
    chk("shift0_lit", o_alu_data, 32'hDEAD_BEEF);
    set_in(32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 4'd3, 1'b0);
    step("slt");
    chk("slt_lit", o_alu_data, 32'd1);
    i_alu_op = 4'd4;
    step("sltu");
    chk("sltu_lit", o_alu_data, 32'd0);

    set_in(32'h8000_0000, 32'd1, 32'h0, 32'h0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("br_signed");
    chk("br_signed_lit", {30'd0, o_br_less, o_br_equal}, 32'd2);
    i_br_un = 1'b1;
    step("br_unsigned");
    chk("br_unsigned_lit", {30'd0, o_br_less, o_br_equal}, 32'd0);
    set_in(32'h1234, 32'h1234, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0);
    step("br_equal");
    chk("br_equal_lit", {30'd0, o_br_less, o_br_equal}, 32'd1);

    set_in(32'h0, 32'h0, 32'h100, {20'h00001, 12'h0}, 3'd3, 1'b1, 1'b1, 4'd0, 1'b0);
    step("auipc");
    chk("auipc_lit", o_alu_data, 32'h1100);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] r1;
      r1 = $urandom;
      set_in(r1, ($urandom_range(0, 7) == 0) ? r1 : $urandom, $urandom, $urandom,
             3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             4'($urandom_range(0, 15)), 1'($urandom));
      step("rand");
      chk("rand_flag_excl", {31'd0, o_br_less & o_br_equal}, 32'd0);
    end

    set_in(32'h7, 32'h9, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0);
    step("pre_reset");
    #3 i_reset = 1'b1;
    #1 chk_zero("reset_async");
    @(posedge i_clk);
    #1 chk_zero("reset_hold_edge");
    set_in(32'd100, 32'd50, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0);
    #2 i_reset = 1'b0;
    #1 chk_zero("reset_no_stale");
    prev_alu = 32'd0; have_prev = 1;
    step("post_reset");
    chk("post_reset_lit", o_alu_data, 32'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- RV32I execute-stage block combining three functions: immediate generator, branch comparator, and ALU with operand-select muxes.
- Takes decoded control plus register/PC values from the decode stage and produces ALU result, immediate and branch flags.
- All outputs are registered once; results feed the pipeline register into memory/write-back and branch resolution.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_instr  in  25  instruction bits [31:7]; bit n of the port is instruction bit n+7.
- i_imm_sel  in  3  immediate format select.
- i_pc  in  32  PC of the instruction.
- i_rs1_data  in  32  register-file rs1 value.
- i_rs2_data  in  32  register-file rs2 value.
- i_opa_sel  in  1  ALU operand A source: 0 = rs1, 1 = pc.
- i_opb_sel  in  1  ALU operand B source: 0 = rs2, 1 = immediate.
- i_alu_op  in  4  ALU operation.
- i_br_un  in  1  branch comparison mode: 1 = unsigned, 0 = signed.
- o_alu_data  out  32  registered ALU result.
- o_imm  out  32  registered immediate.
- o_br_less  out  1  registered flag: rs1 < rs2.
- o_br_equal  out  1  registered flag: rs1 == rs2.

Behaviour:
- Reset: asynchronous assertion clears all outputs to 0 immediately. First capture occurs at the first rising edge after deassertion.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N; a new result every cycle; no handshake, no stall.

Immediate generation (ins = full instruction bit index):
- 000 I: sext(ins[31:20]).
- 001 S: sext({ins[31:25], ins[11:7]}).
- 010 B: sext({ins[31], ins[7], ins[30:25], ins[11:8], 0}).
- 011 U: {ins[31:12], 12'b0}.
- 100 J: sext({ins[31], ins[19:12], ins[20], ins[30:21], 0}).
- 101..111: 0.
- Sign extension always uses ins[31].

Operand muxes:
- A = i_opa_sel ? i_pc : rs1.
- B = i_opb_sel ? imm : rs2, using the immediate generated this same cycle, not the registered o_imm.

ALU ops:
- 0 ADD: A+B, modulo 2^32, overflow ignored.
- 1 SUB: A-B, modulo 2^32.
- 2 SLL: A << B[4:0].
- 3 SLT: signed A<B, result 1 or 0.
- 4 SLTU: unsigned A<B, result 1 or 0.
- 5 XOR.
- 6 SRL: logical A >> B[4:0].
- 7 SRA: arithmetic A >> B[4:0].
- 8 OR.
- 9 AND.
- 10 PASSB: result = B (LUI).
- 11..15: result 0.
- Shift amounts use only B[4:0]; B[31:5] is ignored.

Branch compare:
- Always compares rs1 and rs2, never the muxed operands.
- equal = (rs1 == rs2), independent of i_br_un.
- less = signed or unsigned rs1 < rs2 per i_br_un.
- less and equal are never both 1.

Boundaries:
- 0x80000000 vs 0x00000001: signed less = 1, unsigned less = 0.
- Shift by 0 passes A unchanged.
- SRA of a negative value by 31 gives 0xFFFFFFFF.
- Reset asserted mid-stream clears outputs that same instant; no stale result is presented afterwards.

Test Plan:
1. Reset behaviour: assert reset with nonzero inputs -> all outputs 0 immediately and held while reset is high. Deassert -> after one edge, o_alu_data reflects the inputs.
2. ADD vs ADDI-style operand select:
   - rs1=5, rs2=7, op=0, opb_sel=0 -> o_alu_data=12.
   - opb_sel=1, imm_sel=000, ins[31:20]=0xFFF -> o_imm=0xFFFFFFFF, o_alu_data=4.
3. Immediate formats:
   - S with ins[31:25]=0x7F, ins[11:7]=0x1E -> 0xFFFFFFFE.
   - U with ins[31:12]=0x12345 -> 0x12345000.
   - B and J with ins[31]=1 -> negative, bit0=0.
   - imm_sel=111 -> 0.
4. Shifts and compares:
   - A=0x80000000, B=31: SRA -> 0xFFFFFFFF; SRL -> 0x00000001.
   - B=0x21 with SLL: effective shift 1, A=1 -> 2.
   - SLT(0xFFFFFFFF, 1) -> 1; SLTU of the same -> 0.
5. Branch flags:
   - rs1=0x80000000, rs2=1: br_un=0 -> less=1, equal=0; br_un=1 -> less=0, equal=0.
   - rs1=rs2=0x1234 -> equal=1, less=0.
6. AUIPC/JAL-style and back-to-back streaming:
   - pc=0x100, opa_sel=1, opb_sel=1, U-imm 0x1000, op=ADD -> 0x1100.
   - Change inputs every cycle -> each result appears exactly one cycle after its inputs.
